// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter
//   Round-robin arbiter that lets four requesters share one external
//   bitwise logic unit. A request is accepted in IDLE, its opcode and
//   operands are latched, the shared unit is started with a one-cycle
//   pulse, and the arbiter waits (bounded by TIMEOUT cycles) for the
//   unit's completion before pulsing done for the granted requester.
//
// Parameters
//   WIDTH    operand/result width in bits
//   TIMEOUT  maximum WAIT cycles before the transaction is aborted (1..255)
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   req[3:0]              per-requester request
//   req_op[7:0]           2-bit opcode per requester (00 AND, 01 OR, 10 XOR, 11 NOT A)
//   req_a, req_b          per-requester operands, slice [WIDTH*i +: WIDTH]
//   gnt[3:0]              one-hot grant, held ISSUE..RESP, zero in IDLE
//   done[3:0]             one-hot completion pulse during RESP
//   result, err           outcome of the last completed transaction
//   busy                  FSM not in IDLE
//   unit_start            one-cycle start pulse to the shared unit
//   unit_op/unit_a/unit_b latched operation presented to the shared unit
//   unit_done, unit_y     completion and result from the shared unit
module logic_unit_arbiter #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         req,
  input  logic [7:0]         req_op,
  input  logic [4*WIDTH-1:0] req_a,
  input  logic [4*WIDTH-1:0] req_b,
  output logic [3:0]         gnt,
  output logic [3:0]         done,
  output logic [WIDTH-1:0]   result,
  output logic               err,
  output logic               busy,
  output logic               unit_start,
  output logic [1:0]         unit_op,
  output logic [WIDTH-1:0]   unit_a,
  output logic [WIDTH-1:0]   unit_b,
  input  logic               unit_done,
  input  logic [WIDTH-1:0]   unit_y
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       ptr;
  logic [7:0]       cnt;
  logic [2:0]       pick;
  logic             sel_vld;
  logic [1:0]       sel_idx;
  logic             timeout_hit;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  // First set request bit searching upward from p+1, wrapping mod 4.
  // Returns {valid, index}.
  function automatic logic [2:0] rr_pick(input logic [1:0] p, input logic [3:0] r);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      idx = p + 2'(k);
      if (r[idx] && !rr_pick[2]) rr_pick = {1'b1, idx};
    end
  endfunction

  assign pick    = rr_pick(ptr, req);
  assign sel_vld = pick[2];
  assign sel_idx = pick[1:0];

  // The counter holds the number of completed WAIT cycles, so the
  // TIMEOUT-th WAIT cycle is the one that sees cnt == TIMEOUT-1.
  assign timeout_hit = (cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    unit_start = 1'b0;
    done       = 4'b0000;
    unit_op    = 2'b00;
    unit_a     = '0;
    unit_b     = '0;
    case (state)
      IDLE: begin
        if (sel_vld) state_nxt = ISSUE;
      end
      ISSUE: begin
        busy       = 1'b1;
        unit_start = 1'b1;
        unit_op    = op_q;
        unit_a     = a_q;
        unit_b     = b_q;
        state_nxt  = WAIT;
      end
      WAIT: begin
        busy    = 1'b1;
        unit_op = op_q;
        unit_a  = a_q;
        unit_b  = b_q;
        if (unit_done || timeout_hit) state_nxt = RESP;
      end
      RESP: begin
        busy      = 1'b1;
        done      = gnt;
        unit_op   = op_q;
        unit_a    = a_q;
        unit_b    = b_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers: grant, priority pointer, wait counter, outcome.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt    <= 4'b0000;
      ptr    <= 2'd3;
      cnt    <= 8'd0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_vld) gnt <= 4'b0001 << sel_idx;
        end
        ISSUE: begin
          cnt <= 8'd0;
        end
        WAIT: begin
          cnt <= cnt + 8'd1;
          // unit_done wins over a coincident timeout
          if (unit_done) begin
            result <= unit_y;
            err    <= 1'b0;
          end else if (timeout_hit) begin
            result <= '0;
            err    <= 1'b1;
          end
        end
        RESP: begin
          ptr <= (gnt[1] ? 2'd1 : 2'd0) | (gnt[2] ? 2'd2 : 2'd0) | (gnt[3] ? 2'd3 : 2'd0);
          gnt <= 4'b0000;
        end
        default: ;
      endcase
    end
  end

  // Operand latch: only meaningful while busy, outputs are gated to zero
  // otherwise, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (state == IDLE && sel_vld) begin
      op_q <= req_op[2*sel_idx +: 2];
      a_q  <= req_a[WIDTH*sel_idx +: WIDTH];
      b_q  <= req_b[WIDTH*sel_idx +: WIDTH];
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter with a scoreboard of expected
// completions and an emulated shared logic unit.
module tb_logic_unit_arbiter;
  localparam int W  = 8;
  localparam int TO = 6;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       req;
  logic [7:0]       req_op;
  logic [4*W-1:0]   req_a;
  logic [4*W-1:0]   req_b;
  logic [3:0]       gnt;
  logic [3:0]       done;
  logic [W-1:0]     result;
  logic             err;
  logic             busy;
  logic             unit_start;
  logic [1:0]       unit_op;
  logic [W-1:0]     unit_a;
  logic [W-1:0]     unit_b;
  logic             unit_done;
  logic [W-1:0]     unit_y;

  typedef struct packed {
    logic [3:0]   done;
    logic [W-1:0] result;
    logic         err;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  logic [1:0] m_ptr;

  logic_unit_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .gnt(gnt), .done(done),
    .result(result), .err(err), .busy(busy), .unit_start(unit_start),
    .unit_op(unit_op), .unit_a(unit_a), .unit_b(unit_b),
    .unit_done(unit_done), .unit_y(unit_y)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] lu(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  function automatic int pick(input logic [1:0] p, input logic [3:0] r);
    for (int k = 1; k <= 4; k++)
      if (r[(int'(p) + k) % 4]) return (int'(p) + k) % 4;
    return 0;
  endfunction

  // One transaction. dly = WAIT cycle in which the unit answers (0 = never).
  // spur drives unit_done in IDLE/ISSUE; mangle drops req and scrambles
  // operands right after the latch.
  task automatic txn(input string tag, input logic [3:0] r, input logic [7:0] ops,
                     input logic [4*W-1:0] a, input logic [4*W-1:0] b,
                     input int dly, input logic spur, input logic mangle);
    int   idx;
    int   lat;
    int   k_seen;
    logic good;
    exp_t e;
    exp_t got;
    idx    = pick(m_ptr, r);
    good   = (dly >= 1 && dly <= TO);
    lat    = good ? dly : TO;
    e.done = 4'b0001 << idx;
    e.op   = ops[2*idx +: 2];
    e.a    = a[W*idx +: W];
    e.b    = b[W*idx +: W];
    e.result = good ? lu(e.op, e.a, e.b) : '0;
    e.err    = !good;
    sb.push_back(e);

    req = r; req_op = ops; req_a = a; req_b = b;
    unit_done = spur; unit_y = 8'hA5;
    check({tag, " idle_gnt"}, 64'(gnt), 64'(0));
    @(negedge clk);
    check({tag, " start"}, 64'(unit_start), 64'(1));
    check({tag, " gnt"}, 64'(gnt), 64'(e.done));
    check({tag, " unit_op"}, 64'(unit_op), 64'(e.op));
    check({tag, " unit_a"}, 64'(unit_a), 64'(e.a));
    check({tag, " unit_b"}, 64'(unit_b), 64'(e.b));
    if (mangle) begin
      req = 4'b0000; req_op = ~ops; req_a = ~a; req_b = ~b;
    end
    @(negedge clk);
    check({tag, " start_once"}, 64'(unit_start), 64'(0));
    k_seen = 0;
    for (int k = 1; k <= TO + 2; k++) begin
      unit_done = (k == dly);
      unit_y    = (k == dly) ? lu(unit_op, unit_a, unit_b) : 8'h5A;
      @(negedge clk);
      unit_done = 1'b0;
      if (done != 4'b0000) begin
        k_seen = k;
        break;
      end
    end
    check({tag, " latency"}, 64'(k_seen), 64'(lat));
    got = sb.pop_front();
    check({tag, " done"}, 64'(done), 64'(got.done));
    check({tag, " result"}, 64'(result), 64'(got.result));
    check({tag, " err"}, 64'(err), 64'(got.err));
    check({tag, " gnt_hold"}, 64'(gnt), 64'(got.done));
    check({tag, " a_hold"}, 64'(unit_a), 64'(got.a));
    @(negedge clk);
    check({tag, " done_clr"}, 64'(done), 64'(0));
    check({tag, " gnt_clr"}, 64'(gnt), 64'(0));
    check({tag, " idle_a"}, 64'(unit_a), 64'(0));
    check({tag, " result_hold"}, 64'({err, result}), 64'({got.err, got.result}));
    m_ptr = 2'(idx);
    req = 4'b0000;
  endtask

  initial begin
    reset = 1'b0; req = '0; req_op = '0; req_a = '0; req_b = '0;
    unit_done = 1'b0; unit_y = '0;
    #1 reset = 1'b1;
    #1;
    check("rst busy", 64'(busy), 64'(0));
    check("rst outs", 64'({gnt, done, result, err, unit_start, unit_op, unit_a, unit_b}), 64'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_ptr = 2'd3;

    // Round robin from reset: 0,1,2,3 then 0
    txn("rr0", 4'b1111, 8'b11_10_01_00, 32'hC3_5A_0F_F0, 32'h3C_A5_F0_FF, 1, 1'b0, 1'b0);
    txn("rr1", 4'b1111, 8'b11_10_01_00, 32'hC3_5A_0F_F0, 32'h3C_A5_F0_FF, 2, 1'b0, 1'b0);
    txn("rr2", 4'b1111, 8'b11_10_01_00, 32'hC3_5A_0F_F0, 32'h3C_A5_F0_FF, 3, 1'b0, 1'b0);
    txn("rr3", 4'b1111, 8'b11_10_01_00, 32'hC3_5A_0F_F0, 32'h3C_A5_F0_FF, 1, 1'b0, 1'b0);
    txn("rr4", 4'b1111, 8'b00_01_10_11, 32'h11_22_33_44, 32'h88_77_66_55, 2, 1'b0, 1'b0);

    // Single requester OR 0x0F|0xF0
    txn("single", 4'b0001, 8'b00_00_00_01, 32'h00_00_00_0F, 32'h00_00_00_F0, 2, 1'b0, 1'b0);

    // Timeout, then a good transaction clears err
    txn("tmo", 4'b0100, 8'b00_10_00_00, 32'h00_6B_00_00, 32'h00_9D_00_00, 0, 1'b0, 1'b0);
    txn("tmo_clear", 4'b1000, 8'b10_00_00_00, 32'hA1_00_00_00, 32'h1A_00_00_00, 4, 1'b0, 1'b0);

    // unit_done coincides with the timeout cycle
    txn("coinc", 4'b0010, 8'b00_00_10_00, 32'h00_00_E7_00, 32'h00_00_7E_00, TO, 1'b0, 1'b0);

    // Spurious unit_done in IDLE/ISSUE, operands changed after latch, req dropped
    txn("spur", 4'b0001, 8'b00_00_00_10, 32'h00_00_00_96, 32'h00_00_00_3C, 3, 1'b1, 1'b1);

    // Reset asserted in WAIT
    req = 4'b0100; req_op = 8'h00; req_a = '1; req_b = '1;
    @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    check("mid busy", 64'(busy), 64'(1));
    #2 reset = 1'b1;
    #1;
    check("mid_rst busy", 64'(busy), 64'(0));
    check("mid_rst outs", 64'({gnt, done, result, err, unit_start, unit_op, unit_a, unit_b}), 64'(0));
    @(negedge clk);
    check("mid_rst no_done", 64'(done), 64'(0));
    reset = 1'b0;
    m_ptr = 2'd3;
    @(negedge clk);
    check("post_rst idle", 64'({busy, done}), 64'(0));
    txn("post_rst", 4'b1010, 8'b01_00_11_00, 32'h5F_00_C8_00, 32'h0F_00_00_00, 1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
